// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch buffer.
package instr_fetch_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC_DEF = 16'h0000;

    // One prefetch buffer slot: the fetch address and the word read from it.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush; supports push and
// pop on the same edge even when full.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, fetch/redirect control, and a small
// prefetch buffer feeding the decoder through a valid/ready handshake.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEF,
    parameter int    DEPTH    = 2            // legal range 2..4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WORD_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_instr,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    word_t            pc_q, pc_d;
    logic             deq;
    logic             fetch;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign rom_addr  = pc_q;
    assign out_valid = ~fifo_empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // A full buffer can still accept a fetch when the head leaves on the same edge.
    always_comb begin
        deq            = out_valid & out_ready;
        fetch          = fetch_en & ~redirect & (~fifo_full | deq);
        wr_entry.pc    = pc_q;
        wr_entry.instr = rom_instr;
        pc_d           = pc_q;
        if (redirect)   pc_d = redirect_pc;
        else if (fetch) pc_d = pc_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    // A handshake coinciding with a redirect is consumed; the flush discards the slot.
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (fetch),
        .pop   (deq & ~redirect),
        .wdata (wr_entry),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        assert (fifo_empty == (fifo_count == '0));
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a queue-based model.
module tb_instr_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rom_addr, rom_instr, redirect_pc, out_instr, out_pc;
    logic        fetch_en, redirect, out_valid, out_ready;

    always #5 clk = ~clk;

    assign rom_instr = rom_addr ^ 16'hA5A5;

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_instr   (rom_instr),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];      // {pc, instr} in FIFO order
    logic [15:0] acc[$];    // pcs consumed by the decoder
    logic [15:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cmp_model();
        chk("rom_addr", {16'h0, rom_addr}, {16'h0, m_pc});
        chk("out_valid", {31'h0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        if (q.size() != 0) begin
            chk("out_pc", {16'h0, out_pc}, {16'h0, q[0][31:16]});
            chk("out_instr", {16'h0, out_instr}, {16'h0, q[0][15:0]});
        end
        chk("count", 32'(dut.u_fifo.count), 32'(q.size()));
    endtask

    // Inputs are applied at the falling edge and held across the next rising edge.
    task automatic step(input logic fe, input logic rd, input logic rdr, input logic [15:0] rpc);
        bit deq, room;
        fetch_en    = fe;
        out_ready   = rd;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clk);
        deq  = (q.size() != 0) && rd;
        room = (q.size() < DEPTH) || deq;
        if (deq) acc.push_back(q[0][31:16]);
        if (rdr) begin
            q.delete();
            m_pc = rpc;
        end else begin
            if (deq) void'(q.pop_front());
            if (fe && room) begin
                q.push_back({m_pc, m_pc ^ 16'hA5A5});
                m_pc = m_pc + 16'd1;
            end
        end
        @(negedge clk);
        cmp_model();
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        out_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        q.delete();
        m_pc = RST_PC;
        @(negedge clk);
        chk("rst_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_rom_addr", {16'h0, rom_addr}, {16'h0, RST_PC});
        chk("rst_out_pc", {16'h0, out_pc}, 32'h0);
        chk("rst_out_instr", {16'h0, out_instr}, 32'h0);
        chk("rst_count", 32'(dut.u_fifo.count), 32'd0);
        chk("rst_rd_ptr", 32'(dut.u_fifo.rd_ptr_q), 32'd0);
        chk("rst_wr_ptr", 32'(dut.u_fifo.wr_ptr_q), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_i [4];
        exp_i = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};

        // Streaming from reset
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 16'h0);
            chk("stream_pc", {16'h0, out_pc}, 32'(i));
            chk("stream_instr", {16'h0, out_instr}, {16'h0, exp_i[i]});
        end

        // Backpressure: buffer fills to DEPTH and holds
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 16'h0);
            chk("bp_hold_pc", {16'h0, out_pc}, 32'h0);
        end
        chk("bp_count", 32'(dut.u_fifo.count), 32'd2);
        chk("bp_rom_addr", {16'h0, rom_addr}, 32'd2);
        for (int i = 1; i <= 2; i++) begin
            step(1, 1, 0, 16'h0);
            chk("bp_rel_valid", {31'h0, out_valid}, 32'd1);
            chk("bp_rel_pc", {16'h0, out_pc}, 32'(i));
        end

        // Redirect with two entries buffered, no handshake
        chk("rd_pre_count", 32'(dut.u_fifo.count), 32'd2);
        step(1, 0, 1, 16'h0040);
        chk("rd_bubble", {31'h0, out_valid}, 32'd0);
        step(1, 1, 0, 16'h0);
        chk("rd_first", {16'h0, out_pc}, 32'h0040);
        step(1, 1, 0, 16'h0);
        chk("rd_second", {16'h0, out_pc}, 32'h0041);

        // Redirect together with a handshake
        step(1, 1, 1, 16'h0080);
        chk("rdh_bubble", {31'h0, out_valid}, 32'd0);
        step(1, 1, 0, 16'h0);
        chk("rdh_first", {16'h0, out_pc}, 32'h0080);
        step(1, 1, 0, 16'h0);
        chk("rdh_second", {16'h0, out_pc}, 32'h0081);
        chk("rdh_acc_last", {16'h0, acc[acc.size()-1]}, 32'h0080);
        chk("rdh_acc_prev", {16'h0, acc[acc.size()-2]}, 32'h0041);

        // PC wrap
        step(1, 1, 1, 16'hFFFE);
        step(1, 1, 0, 16'h0);
        chk("wrap_0", {16'h0, out_pc}, 32'hFFFE);
        step(1, 1, 0, 16'h0);
        chk("wrap_1", {16'h0, out_pc}, 32'hFFFF);
        step(1, 1, 0, 16'h0);
        chk("wrap_2", {16'h0, out_pc}, 32'h0000);

        // Asynchronous reset mid-stream with two entries buffered
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        chk("mrst_pre_count", 32'(dut.u_fifo.count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'h0, out_valid}, 32'd0);
        chk("mrst_rom_addr", {16'h0, rom_addr}, {16'h0, RST_PC});
        q.delete();
        m_pc = RST_PC;
        @(negedge clk);
        cmp_model();
        rst_n = 1'b1;
        step(1, 1, 0, 16'h0);
        chk("mrst_first", {16'h0, out_pc}, {16'h0, RST_PC});

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                               : 16'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the program counter (PC) value loaded at reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the prefetch buffer depth in entries; the legal range is 2 to 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port rom_addr, output, 16 bits: fetch address to the combinational instruction memory.
REQ-006 The block SHALL have port rom_instr, input, 16 bits: the instruction word at rom_addr, valid in the same cycle.
REQ-007 The block SHALL have port fetch_en, input, 1 bit: when high, new fetches are permitted.
REQ-008 The block SHALL have port redirect, input, 1 bit: a branch or jump request that flushes the buffer.
REQ-009 The block SHALL have port redirect_pc, input, 16 bits: the new PC, sampled when redirect is high.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the head buffer entry is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the decoder accepts the head entry.
REQ-012 The block SHALL have port out_instr, output, 16 bits: the instruction word of the head entry.
REQ-013 The block SHALL have port out_pc, output, 16 bits: the address the head entry was fetched from.

Function
REQ-014 rom_addr SHALL equal the PC register at all times; it SHALL be driven combinationally from that register only.
REQ-015 Dequeue SHALL occur on any edge where out_valid and out_ready are both high, removing the head entry.
REQ-016 Fetch SHALL occur on an edge where fetch_en is high, redirect is low, and the buffer is either not full or being dequeued on that same edge.
REQ-017 On a fetch, the block SHALL enqueue {PC, rom_instr} at the tail and set PC to PC+1 modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-018 The buffer SHALL be first-in first-out; a simultaneous fetch and dequeue on a full buffer SHALL leave the count unchanged.
REQ-019 On an edge where redirect is high, the block SHALL empty the buffer, set PC to redirect_pc, and perform no enqueue; redirect takes priority over fetch and dequeue.
REQ-020 A dequeue handshake on the same edge as a redirect SHALL still be counted as consumed by the decoder; the entry is discarded with the flush.
REQ-021 out_valid SHALL be high exactly when the entry count is nonzero; out_instr and out_pc SHALL be the head entry and SHALL be stable while out_valid is high and out_ready is low.
REQ-022 Fetch-to-output latency SHALL be 1 cycle: an instruction fetched on edge N SHALL be presented at the head after edge N if the buffer was empty.
REQ-023 After a redirect on edge N, out_valid SHALL be low in cycle N+1, and the entry fetched from redirect_pc SHALL be presented after edge N+1, given fetch_en is high.
REQ-024 When fetch_en is low, PC and buffer contents SHALL hold, except for dequeues and redirects.
REQ-025 With out_ready held high and fetch_en held high, the block SHALL sustain one instruction per cycle.
REQ-026 The entry count SHALL never exceed DEPTH and never underflow; a dequeue attempt while empty SHALL be impossible because out_valid is low.

Reset
REQ-027 While rst_n is low, PC SHALL be RESET_PC, the count SHALL be 0, the read and write pointers SHALL be 0, out_valid SHALL be 0, and out_instr and out_pc SHALL be 16'h0000.
REQ-028 Reset asserted mid-operation SHALL immediately discard all buffered entries and any redirect in progress.
REQ-029 The first fetch after reset SHALL occur on the first rising edge after rst_n deasserts, given fetch_en is high.

Structure
REQ-030 The shared package SHALL hold the word width constant (16), the RESET_PC default, and the buffer entry typedef {pc, instr}.
REQ-031 The prefetch buffer SHALL be one sub-module, fetch_fifo: a synchronous FIFO with flush, DEPTH entries, and count, full and empty outputs.
REQ-032 instr_fetch SHALL contain only the PC register, the fetch/redirect control, and the fetch_fifo instance.

Verification
REQ-033 Streaming: the bench SHALL use a ROM model with instr = addr ^ 16'hA5A5, hold fetch_en=1 and out_ready=1 from reset, and check that the decoder sees pc 0,1,2,3 with instr A5A5, A5A4, A5A7, A5A6 on consecutive cycles.
REQ-034 Backpressure: the bench SHALL hold out_ready=0 for 5 cycles and check that the count saturates at 2, PC holds at 2, and out_pc stays 0; after releasing out_ready it SHALL check the order 0,1,2 with no gap.
REQ-035 Redirect: the bench SHALL pulse redirect with redirect_pc=16'h0040 while 2 entries are buffered, and check that out_valid is low for 1 cycle and the next outputs are pc 0040 and 0041.
REQ-036 Redirect with handshake: the bench SHALL apply redirect together with out_valid=1 and out_ready=1, and check that the flushed entries are never presented and no duplicate appears.
REQ-037 Wrap: the bench SHALL redirect to 16'hFFFE and check the output pc sequence FFFE, FFFF, 0000.
REQ-038 Reset mid-stream: the bench SHALL assert rst_n=0 asynchronously with 2 entries buffered, check that out_valid=0 and rom_addr=RESET_PC immediately, and after release check that the first output is pc RESET_PC.
